// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM block.
// Holds the counting mode, counter direction and channel slice offset helper.
package pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // LSB position of channel ch inside a flat bus of w-bit fields.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: edge or center counting, boundary and transfer strobe; cnt_o is the registered count.
// No backpressure; holds at 0 (direction up) whenever disabled or the active period is zero.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    input  pwm_mode_e        mode_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             run_o,
    output logic             start_o,
    output logic             xfer_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    logic [CNT_W-1:0] last;
    logic             boundary;

    assign run_o = en_i && (period_i != '0);
    assign last  = period_i - 1'b1;

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (!run_o) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (mode_i == MODE_EDGE) begin
            dir_d = DIR_UP;
            if (cnt_q >= last) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dir_q == DIR_UP) begin
            // Turning values repeat once: flip direction, keep the count.
            if (cnt_q >= last) begin
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == '0) begin
                dir_d    = DIR_UP;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign start_o = run_o && (cnt_q == '0) && (dir_q == DIR_UP);
    assign xfer_o  = boundary || !run_o;

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM on one shared timebase with double-buffered period/duty/mode; 1 cycle cnt-to-pin.
// No backpressure; load is a strobe and the last load before a boundary wins.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned N_CH     = 4,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [CNT_W-1:0]      period_in,
    input  logic [N_CH*CNT_W-1:0] duty_in,
    input  logic                  center_in,
    input  logic [N_CH-1:0]       invert,
    output logic [N_CH-1:0]       pwm_out,
    output logic                  period_start,
    output logic                  update_pending
);

    typedef struct packed {
        pwm_mode_e             mode;
        logic [CNT_W-1:0]      period;
        logic [N_CH*CNT_W-1:0] duty;
    } cfg_t;

    cfg_t             req, act_q, pend_q;
    logic             upd_q, upd_d;
    logic [N_CH-1:0]  pwm_q, pwm_d;
    logic             ps_q;
    logic [CNT_W-1:0] cnt;
    logic             run, start, xfer;

    always_comb begin
        req.mode   = pwm_mode_e'(center_in);
        req.period = period_in;
        req.duty   = duty_in;
    end

    pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .period_i (act_q.period),
        .mode_i   (act_q.mode),
        .cnt_o    (cnt),
        .run_o    (run),
        .start_o  (start),
        .xfer_o   (xfer)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic raw;
        assign raw      = cnt < act_q.duty[ch_lsb(k, CNT_W) +: CNT_W];
        assign pwm_d[k] = (run ? raw : IDLE_LVL) ^ invert[k];
    end

    // A load coinciding with a transfer keeps the flag set for the next boundary.
    assign upd_d = load || (upd_q && !xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= '0;
            pend_q <= '0;
            upd_q  <= 1'b0;
            pwm_q  <= {N_CH{IDLE_LVL}};
            ps_q   <= 1'b0;
        end else begin
            if (load) pend_q <= req;
            if (xfer) act_q <= pend_q;
            upd_q <= upd_d;
            pwm_q <= pwm_d;
            ps_q  <= start;
        end
    end

    assign pwm_out        = pwm_q;
    assign period_start   = ps_q;
    assign update_pending = upd_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected outputs queued as each cycle is driven, checked after the edge.
module tb_pwm_multi;

    localparam logic IDLE = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n, en, load, center_in;
    logic [7:0]  period_in;
    logic [31:0] duty_in;
    logic [3:0]  invert;
    logic [3:0]  pwm_out;
    logic        period_start, update_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [3:0] pwm;
        logic       ps;
        logic       up;
    } exp_t;

    exp_t sb[$];

    pwm_multi #(.CNT_W(8), .N_CH(4), .IDLE_LVL(IDLE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .load           (load),
        .period_in      (period_in),
        .duty_in        (duty_in),
        .center_in      (center_in),
        .invert         (invert),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_pwm(input logic run, input int cnt,
                                           input logic [31:0] d, input logic [3:0] inv);
        logic [3:0] r;
        for (int k = 0; k < 4; k++)
            r[k] = run ? (cnt < int'({24'd0, d[k*8 +: 8]})) : IDLE;
        return r ^ inv;
    endfunction

    function automatic int ctr_cnt(input int j, input int p);
        int m;
        m = j % (2 * p);
        return (m < p) ? m : (2 * p - 1 - m);
    endfunction

    task automatic step(input string tag, input logic [3:0] p, input logic ps, input logic up);
        exp_t e;
        e.tag = tag; e.pwm = p; e.ps = ps; e.up = up;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty got no entry exp one entry");
        end else begin
            e = sb.pop_front();
            checks++;
            assert (pwm_out === e.pwm) else begin
                errors++;
                $error("FAIL %0s pwm_out got %b exp %b", e.tag, pwm_out, e.pwm);
            end
            checks++;
            assert (period_start === e.ps) else begin
                errors++;
                $error("FAIL %0s period_start got %b exp %b", e.tag, period_start, e.ps);
            end
            checks++;
            assert (update_pending === e.up) else begin
                errors++;
                $error("FAIL %0s update_pending got %b exp %b", e.tag, update_pending, e.up);
            end
        end
    endtask

    task automatic cfg_load(input logic [7:0] p, input logic [31:0] d, input logic c);
        en = 1'b0; load = 1'b1; period_in = p; duty_in = d; center_in = c;
        step("cfg_load", exp_pwm(1'b0, 0, d, invert), 1'b0, 1'b1);
        load = 1'b0;
        step("cfg_xfer", exp_pwm(1'b0, 0, d, invert), 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (pwm_out === {4{IDLE}}) else begin
            errors++;
            $error("FAIL %0s pwm_out got %b exp %b", tag, pwm_out, {4{IDLE}});
        end
        checks++;
        assert (period_start === 1'b0 && update_pending === 1'b0) else begin
            errors++;
            $error("FAIL %0s ps/up got %b%b exp 00", tag, period_start, update_pending);
        end
    endtask

    logic [31:0] d_a, d_b, d_x, d_c, d_m, d_f, dcur;
    logic        up;

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; period_in = '0; duty_in = '0;
        center_in = 1'b0; invert = 4'b0010;
        #12;
        check_reset("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step("idle_after_reset", 4'b0010, 1'b0, 1'b0);

        // Edge basic: duties ch3..ch0 = 15,10,3,0 with P=10, then en drop/raise.
        invert = 4'b0000;
        d_a = {8'd15, 8'd10, 8'd3, 8'd0};
        cfg_load(8'd10, d_a, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 36; i++)
            step("edge_basic", exp_pwm(1'b1, i % 10, d_a, invert), (i % 10) == 0, 1'b0);
        en = 1'b0;
        repeat (2) step("en_off", exp_pwm(1'b0, 0, d_a, invert), 1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 12; i++)
            step("en_on", exp_pwm(1'b1, i % 10, d_a, invert), (i % 10) == 0, 1'b0);

        // Center basic with P=8 and one inverted channel.
        invert = 4'b1000;
        d_a = {8'd8, 8'd0, 8'd5, 8'd3};
        cfg_load(8'd8, d_a, 1'b1);
        en = 1'b1;
        for (int j = 0; j < 40; j++)
            step("center_basic", exp_pwm(1'b1, ctr_cnt(j, 8), d_a, invert), (j % 16) == 0, 1'b0);

        // Glitch-free duty updates; two loads in one period, last wins.
        invert = 4'b0000;
        d_a = {8'd8, 8'd6, 8'd4, 8'd2};
        d_b = {8'd7, 8'd7, 8'd7, 8'd7};
        d_x = {8'd5, 8'd5, 8'd5, 8'd5};
        d_c = {8'd0, 8'd9, 8'd1, 8'd7};
        cfg_load(8'd10, d_a, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            load = (i == 4) || (i == 12) || (i == 15);
            period_in = 8'd10; center_in = 1'b0;
            duty_in = (i == 4) ? d_b : (i == 12) ? d_x : d_c;
            dcur = (i < 10) ? d_a : (i < 20) ? d_b : d_c;
            up = (i >= 4 && i <= 8) || (i >= 12 && i <= 18);
            step("glitch_free", exp_pwm(1'b1, i % 10, dcur, invert), (i % 10) == 0, up);
        end
        load = 1'b0;

        // Mode switch mid edge period: takes effect at the wrap.
        d_m = {8'd0, 8'd8, 8'd6, 8'd2};
        for (int i = 30; i < 40; i++) begin
            load = (i == 33); period_in = 8'd8; center_in = 1'b1; duty_in = d_m;
            step("mode_edge", exp_pwm(1'b1, i % 10, d_c, invert), (i % 10) == 0,
                 (i >= 33) && (i <= 38));
        end
        for (int j = 0; j < 48; j++) begin
            load = (j == 37); period_in = 8'd0; center_in = 1'b0;
            step("mode_center", exp_pwm(1'b1, ctr_cnt(j, 8), d_m, invert), (j % 16) == 0,
                 (j >= 37) && (j <= 46));
        end
        load = 1'b0;
        repeat (5) step("period_zero", exp_pwm(1'b0, 0, d_m, invert), 1'b0, 1'b0);
        d_f = {8'd7, 8'd5, 8'd2, 8'd1};
        load = 1'b1; period_in = 8'd5; center_in = 1'b0; duty_in = d_f;
        step("p5_load", exp_pwm(1'b0, 0, d_f, invert), 1'b0, 1'b1);
        load = 1'b0;
        step("p5_xfer", exp_pwm(1'b0, 0, d_f, invert), 1'b0, 1'b0);
        for (int k = 0; k < 12; k++)
            step("p5_run", exp_pwm(1'b1, k % 5, d_f, invert), (k % 5) == 0, 1'b0);

        // Asynchronous reset mid-period clears active values too.
        #2;
        rst_n = 1'b0; invert = 4'b0010;
        #1;
        check_reset("reset_mid");
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;
        repeat (2) step("post_reset_off", 4'b0010, 1'b0, 1'b0);
        en = 1'b1;
        repeat (3) step("post_reset_p0", 4'b0010, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
